atmo_light_ctrl: RTL and testbench

Per-frame controller that estimates atmospheric light A for the dehaze pipeline and drives the `a` input of the transmission stage.
- Monitors the dark-channel stream during each frame and tracks its maximum.
- At each frame boundary (vsync rising edge), commits a new A that is held constant for the whole next frame.
- Guarantees A never changes mid-frame, so the downstream A − dark subtraction stays frame-coherent.

---
 rtl/dehaze_pkg.sv | 17 +
 rtl/atmo_light_ctrl_if.sv | 29 ++
 rtl/frame_edge_det.sv | 22 ++
 rtl/atmo_light_ctrl.sv | 116 +++++++++++
 tb/tb_atmo_light_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/dehaze_pkg.sv
// Shared types and constants for the frame-based dehaze blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dehaze_pkg;

  localparam int PIX_W = 8;

  localparam logic [PIX_W-1:0] A_INIT_DEF = 8'd255;
  localparam logic [PIX_W-1:0] A_MIN_DEF  = 8'd128;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACCUM,
    COMMIT
  } frame_state_t;

endpackage

// File: rtl/atmo_light_ctrl_if.sv
// Pixel-stream in / atmospheric-light out bundle for atmo_light_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; the pixel stream is free-running, qualified by i_de.
// master: pixel source (drives dark_chanel_value, i_hsync, i_vsync, i_de)
// slave : controller  (drives a_out, a_valid, a_update, frame_err, max_dark)
interface atmo_light_ctrl_if;
  import dehaze_pkg::*;

  logic [PIX_W-1:0] dark_chanel_value;
  logic             i_hsync;
  logic             i_vsync;
  logic             i_de;
  logic [PIX_W-1:0] a_out;
  logic             a_valid;
  logic             a_update;
  logic             frame_err;
  logic [PIX_W-1:0] max_dark;

  modport master (
    output dark_chanel_value, i_hsync, i_vsync, i_de,
    input  a_out, a_valid, a_update, frame_err, max_dark
  );

  modport slave (
    input  dark_chanel_value, i_hsync, i_vsync, i_de,
    output a_out, a_valid, a_update, frame_err, max_dark
  );

endinterface

// File: rtl/frame_edge_det.sv
// Vsync rising-edge detector shared by frame-based blocks.
// Latency: frame_edge is combinational in the cycle vsync first reads high.
// Backpressure: none.
// Ports: pixelclk, reset_n (async active-low), vsync in, frame_edge out.
module frame_edge_det (
  input  logic pixelclk,
  input  logic reset_n,
  input  logic vsync,
  output logic frame_edge
);

  logic vs_d;

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) vs_d <= 1'b0;
    else          vs_d <= vsync;
  end

  // A held-high vsync produces exactly one edge.
  assign frame_edge = vsync & ~vs_d;

endmodule

// File: rtl/atmo_light_ctrl.sv
// Per-frame atmospheric light estimator: tracks the dark-channel maximum and
// commits a clamped (optionally IIR-smoothed) A at each vsync rising edge.
// Latency: a_update/frame_err in cycle N+1, new a_out in N+2 after edge cycle N.
// Backpressure: none; every i_de pixel is consumed in its cycle.
// Ports: pixelclk, reset_n (async active-low), bus (atmo_light_ctrl_if.slave).
// Build option: define ATMO_IIR_EN for temporal smoothing of committed A.
module atmo_light_ctrl
  import dehaze_pkg::*;
#(
  parameter logic [PIX_W-1:0] A_INIT     = A_INIT_DEF,
  parameter logic [PIX_W-1:0] A_MIN      = A_MIN_DEF,
  parameter int               CNT_W      = 24,
  parameter logic [CNT_W-1:0] MIN_PIXELS = CNT_W'(1024)
) (
  input  logic               pixelclk,
  input  logic               reset_n,
  atmo_light_ctrl_if.slave   bus
);

  frame_state_t     state;
  logic             frame_edge;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [PIX_W-1:0] max_q;
  logic [PIX_W-1:0] max_inc;
  logic [PIX_W-1:0] a_q;
  logic [PIX_W-1:0] a_raw;
  logic [PIX_W-1:0] a_next;
  logic             a_valid_q;
  logic             a_update_q;
  logic             frame_err_q;
  logic             commit_ok;

  frame_edge_det u_frame_edge_det (
    .pixelclk   (pixelclk),
    .reset_n    (reset_n),
    .vsync      (bus.i_vsync),
    .frame_edge (frame_edge)
  );

  // Count/max including this cycle's pixel, so an edge-cycle pixel still
  // lands in the frame that is ending.
  always_comb begin
    cnt_inc = pix_cnt;
    max_inc = max_q;
    if (bus.i_de) begin
      if (~&pix_cnt) cnt_inc = pix_cnt + 1'b1;
      if (bus.dark_chanel_value > max_q) max_inc = bus.dark_chanel_value;
    end
    commit_ok = (cnt_inc >= MIN_PIXELS);
  end

  assign a_raw = (max_q < A_MIN) ? A_MIN : max_q;

`ifdef ATMO_IIR_EN
  // 3*a + raw + 2 peaks at 1022, so 10 bits never overflow.
  logic [9:0] iir_sum;
  assign iir_sum = {2'b00, a_q} + {1'b0, a_q, 1'b0} + {2'b00, a_raw} + 10'd2;
  assign a_next  = a_valid_q ? iir_sum[9:2] : a_raw;
`else
  assign a_next  = a_raw;
`endif

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT_FRAME;
      pix_cnt     <= '0;
      max_q       <= '0;
      a_q         <= A_INIT;
      a_valid_q   <= 1'b0;
      a_update_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      a_update_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          // The partial frame after reset is discarded.
          if (frame_edge) begin
            state   <= ACCUM;
            pix_cnt <= '0;
            max_q   <= '0;
          end
        end
        ACCUM: begin
          pix_cnt <= cnt_inc;
          max_q   <= max_inc;
          if (frame_edge) begin
            state       <= COMMIT;
            a_update_q  <= commit_ok;
            frame_err_q <= ~commit_ok;
          end
        end
        COMMIT: begin
          // a_update_q is high exactly in a COMMIT cycle whose frame qualified.
          if (a_update_q) begin
            a_q       <= a_next;
            a_valid_q <= 1'b1;
          end
          // A pixel in this cycle is the first pixel of the new frame.
          pix_cnt <= bus.i_de ? CNT_W'(1) : '0;
          max_q   <= bus.i_de ? bus.dark_chanel_value : '0;
          state   <= ACCUM;
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

  assign bus.a_out     = a_q;
  assign bus.a_valid   = a_valid_q;
  assign bus.a_update  = a_update_q;
  assign bus.frame_err = frame_err_q;
  assign bus.max_dark  = max_q;

endmodule

// File: tb/tb_atmo_light_ctrl.sv
// Directed + randomized frame bench for atmo_light_ctrl with a frame-level
// reference model (pixel count and peak per frame, clamp, optional smoothing).
module tb_atmo_light_ctrl;

  localparam int A_INIT     = 255;
  localparam int A_MIN      = 128;
  localparam int MIN_PIXELS = 1024;
`ifdef ATMO_IIR_EN
  localparam bit IIR = 1'b1;
`else
  localparam bit IIR = 1'b0;
`endif

  logic pixelclk = 1'b0;
  logic reset_n  = 1'b0;

  atmo_light_ctrl_if bus ();

  atmo_light_ctrl dut (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 pixelclk = ~pixelclk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_a;
  bit m_valid;
  int carry_cnt;
  int carry_max;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vs, input logic de, input int v);
    bus.i_vsync           = vs;
    bus.i_de              = de;
    bus.i_hsync           = ~de;
    bus.dark_chanel_value = v[7:0];
    @(posedge pixelclk);
    #1;
  endtask

  task automatic model_reset();
    m_a       = A_INIT;
    m_valid   = 1'b0;
    carry_cnt = 0;
    carry_max = 0;
  endtask

  // One frame body (vsync low) then its closing edge at cycle N.
  task automatic send_frame(input int npix, input int peak,
                            input bit edge_pix, input int edge_val,
                            input bit commit_pix, input int commit_val);
    int cnt, mx, pk_idx, v, raw;
    bit ok;
    cnt    = carry_cnt;
    mx     = carry_max;
    pk_idx = $urandom_range(0, npix - 1);
    for (int i = 0; i < npix; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, $urandom_range(0, 255));
      v = (i == pk_idx) ? peak : $urandom_range(0, peak);
      drive(1'b0, 1'b1, v);
      cnt++;
      if (v > mx) mx = v;
    end
    if (edge_pix) begin
      cnt++;
      if (edge_val > mx) mx = edge_val;
    end
    drive(1'b1, edge_pix, edge_val);
    // cycle N+1
    ok = (cnt >= MIN_PIXELS);
    chk("max_dark@N+1", bus.max_dark, mx);
    chk("a_update@N+1", bus.a_update, ok);
    chk("frame_err@N+1", bus.frame_err, !ok);
    chk("a_out_hold@N+1", bus.a_out, m_a);
    if (ok) begin
      raw = (mx < A_MIN) ? A_MIN : mx;
      m_a = (IIR && m_valid) ? (3 * m_a + raw + 2) / 4 : raw;
      m_valid = 1'b1;
    end
    drive(1'b1, commit_pix, commit_val);
    // cycle N+2
    carry_cnt = commit_pix ? 1 : 0;
    carry_max = commit_pix ? commit_val : 0;
    chk("a_out@N+2", bus.a_out, m_a);
    chk("a_valid@N+2", bus.a_valid, m_valid);
    chk("a_update_low@N+2", bus.a_update, 1'b0);
    chk("frame_err_low@N+2", bus.frame_err, 1'b0);
    chk("max_dark_restart@N+2", bus.max_dark, carry_max);
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_vsync           = 1'b0;
    bus.i_de              = 1'b0;
    bus.i_hsync           = 1'b0;
    bus.dark_chanel_value = 8'd0;
    model_reset();

    // Reset values
    repeat (3) @(posedge pixelclk);
    #1;
    chk("rst_a_out", bus.a_out, A_INIT);
    chk("rst_a_valid", bus.a_valid, 1'b0);
    chk("rst_a_update", bus.a_update, 1'b0);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    chk("rst_max_dark", bus.max_dark, 0);
    reset_n = 1'b1;

    // Partial frame after reset: ignored, its edge commits nothing
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 250);
    chk("wait_max_dark", bus.max_dark, 0);
    drive(1'b1, 1'b1, 250);
    chk("partial_no_update", bus.a_update, 1'b0);
    chk("partial_no_err", bus.frame_err, 1'b0);
    // Held-high vsync: no further edges
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 0);
      chk("held_vs_no_pulse", bus.a_update | bus.frame_err, 1'b0);
    end
    chk("partial_a_out", bus.a_out, A_INIT);
    drive(1'b0, 1'b0, 0);

    // Directed frames
    send_frame(2048, 200, 1'b0, 0, 1'b0, 0);     // peak 200
    send_frame(1100, 90, 1'b0, 0, 1'b0, 0);      // below clamp
    send_frame(500, 220, 1'b0, 0, 1'b0, 0);      // too few pixels
    send_frame(1024, 60, 1'b0, 0, 1'b1, 170);    // exactly MIN_PIXELS, max restarted
    send_frame(1023, 50, 1'b0, 0, 1'b0, 0);      // carried COMMIT pixel makes 1024
    send_frame(1023, 100, 1'b0, 0, 1'b0, 0);     // one short
    send_frame(2048, 200, 1'b0, 0, 1'b0, 0);
    send_frame(1500, 100, 1'b0, 0, 1'b0, 0);     // smoothing step from 200
    send_frame(1023, 120, 1'b1, 240, 1'b0, 0);   // edge-cycle pixel counts

    // Randomized frames
    for (int f = 0; f < 4; f++)
      send_frame($urandom_range(1000, 1300), $urandom_range(0, 255),
                 1'($urandom_range(0, 1)), $urandom_range(0, 255),
                 1'($urandom_range(0, 1)), $urandom_range(0, 255));

    // Mid-frame asynchronous reset
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 250);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_a_out", bus.a_out, A_INIT);
    chk("midrst_a_valid", bus.a_valid, 1'b0);
    chk("midrst_max_dark", bus.max_dark, 0);
    @(posedge pixelclk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 230);
    chk("midrst_wait_max", bus.max_dark, 0);
    drive(1'b1, 1'b0, 0);
    chk("midrst_no_update", bus.a_update, 1'b0);
    chk("midrst_no_err", bus.frame_err, 1'b0);
    drive(1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 0);
    send_frame(1100, 150, 1'b0, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
